// File: rtl/ruby_lsu_l1d_resp_fmt_if.sv
// LSU <-> L1D responder bundle: request port, cache data return, response port and status.
// slave = the responder, master = the LSU/cache side driving it.
interface ruby_lsu_l1d_resp_fmt_if #(
  parameter int LSU_ID_WIDTH   = 4,
  parameter int ROB_TAG_WIDTH  = 6,
  parameter int PREG_TAG_WIDTH = 7,
  parameter int PADDR_WIDTH    = 56,
  parameter int XLEN           = 64,
  parameter int DEPTH          = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      req_vld_i;
  logic                      req_rdy_o;
  logic [LSU_ID_WIDTH-1:0]   req_lsu_id_i;
  logic [ROB_TAG_WIDTH-1:0]  req_rob_id_i;
  logic [PREG_TAG_WIDTH-1:0] req_ld_rd_idx_i;
  logic [5:0]                req_type_i;
  logic [PADDR_WIDTH-1:0]    req_paddr_i;

  logic                      dat_vld_i;
  logic                      dat_rdy_o;
  logic [XLEN-1:0]           dat_i;
  logic                      dat_err_i;

  logic                      resp_vld_o;
  logic                      resp_rdy_i;
  logic [LSU_ID_WIDTH-1:0]   resp_lsu_id_o;
  logic [ROB_TAG_WIDTH-1:0]  resp_rob_id_o;
  logic [PREG_TAG_WIDTH-1:0] resp_ld_rd_idx_o;
  logic [5:0]                resp_req_type_o;
  logic [XLEN-1:0]           resp_ld_data_o;
  logic                      resp_err_o;

  logic [CNT_W-1:0]          count_o;
  logic                      proto_err_o;

  modport slave (
    input  req_vld_i, req_lsu_id_i, req_rob_id_i, req_ld_rd_idx_i, req_type_i, req_paddr_i,
    output req_rdy_o,
    input  dat_vld_i, dat_i, dat_err_i,
    output dat_rdy_o,
    input  resp_rdy_i,
    output resp_vld_o, resp_lsu_id_o, resp_rob_id_o, resp_ld_rd_idx_o, resp_req_type_o,
    output resp_ld_data_o, resp_err_o, count_o, proto_err_o
  );

  modport master (
    output req_vld_i, req_lsu_id_i, req_rob_id_i, req_ld_rd_idx_i, req_type_i, req_paddr_i,
    input  req_rdy_o,
    output dat_vld_i, dat_i, dat_err_i,
    input  dat_rdy_o,
    output resp_rdy_i,
    input  resp_vld_o, resp_lsu_id_o, resp_rob_id_o, resp_ld_rd_idx_o, resp_req_type_o,
    input  resp_ld_data_o, resp_err_o, count_o, proto_err_o
  );
endinterface

// File: rtl/ruby_lsu_l1d_resp_fmt.sv
// L1D responder: queues LSU request metadata in order, pairs each entry with the returned
// doubleword, aligns/extends it by req_type and presents a registered response.
module ruby_lsu_l1d_resp_fmt #(
  parameter int LSU_ID_WIDTH   = 4,
  parameter int ROB_TAG_WIDTH  = 6,
  parameter int PREG_TAG_WIDTH = 7,
  parameter int PADDR_WIDTH    = 56,
  parameter int XLEN           = 64,
  parameter int DEPTH          = 4
) (
  input logic                   clk,
  input logic                   rst,
  ruby_lsu_l1d_resp_fmt_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Access size class: 0 byte, 1 half, 2 word, 3 doubleword.
  function automatic logic [1:0] acc_size(input logic [5:0] t);
    logic [1:0] s;
    case (t)
      6'd1, 6'd2, 6'd8:                                     s = 2'd0;
      6'd3, 6'd4, 6'd9:                                     s = 2'd1;
      6'd5, 6'd6, 6'd10, 6'd12, 6'd14, 6'd34, 6'd35:        s = 2'd2;
      6'd7, 6'd11, 6'd13, 6'd15, 6'd36, 6'd37:              s = 2'd3;
      default: s = (t >= 6'd16 && t <= 6'd33) ? (t[0] ? 2'd3 : 2'd2) : 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [5:0] t, input logic [2:0] off);
    logic m;
    case (acc_size(t))
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      2'd3:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] fmt_load(input logic [5:0] t, input logic [2:0] off,
                                                input logic [XLEN-1:0] dat);
    logic        [XLEN-1:0] sh;
    logic signed [XLEN-1:0] r;
    sh = dat >> {off, 3'b000};
    case (t)
      6'd1:                 r = XLEN'($signed(sh[7:0]));
      6'd2:                 r = $signed({56'd0, sh[7:0]});
      6'd3:                 r = XLEN'($signed(sh[15:0]));
      6'd4:                 r = $signed({48'd0, sh[15:0]});
      6'd5, 6'd12:          r = XLEN'($signed(sh[31:0]));
      6'd6:                 r = $signed({32'd0, sh[31:0]});
      6'd7, 6'd13, 6'd36:   r = $signed(sh);
      6'd34:                r = $signed({32'hFFFF_FFFF, sh[31:0]});
      6'd14, 6'd15:         r = $signed({63'd0, dat[0]});
      default: begin
        if (t >= 6'd16 && t <= 6'd33)
          r = t[0] ? $signed(sh) : XLEN'($signed(sh[31:0]));
        else
          r = '0;
      end
    endcase
    return $unsigned(r);
  endfunction

  logic [LSU_ID_WIDTH-1:0]   q_lsu_id    [DEPTH];
  logic [ROB_TAG_WIDTH-1:0]  q_rob_id    [DEPTH];
  logic [PREG_TAG_WIDTH-1:0] q_ld_rd_idx [DEPTH];
  logic [5:0]                q_type      [DEPTH];
  logic [2:0]                q_off       [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             proto_err;
  logic             req_rdy, dat_rdy, dat_hs, push, pop, empty;

  logic                      vld_p1;
  logic [LSU_ID_WIDTH-1:0]   lsu_id_p1;
  logic [ROB_TAG_WIDTH-1:0]  rob_id_p1;
  logic [PREG_TAG_WIDTH-1:0] ld_rd_idx_p1;
  logic [5:0]                type_p1;
  logic [XLEN-1:0]           data_p1;
  logic                      err_p1;

  logic [PADDR_WIDTH-4:0] unused_paddr_hi;
  assign unused_paddr_hi = bus.req_paddr_i[PADDR_WIDTH-1:3];

  assign empty   = (count == '0);
  assign req_rdy = (count != CNT_W'(DEPTH));
  assign dat_rdy = !vld_p1 || bus.resp_rdy_i;
  assign dat_hs  = bus.dat_vld_i && dat_rdy;
  assign push    = bus.req_vld_i && req_rdy;
  assign pop     = dat_hs && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      q_lsu_id[wr_ptr]    <= bus.req_lsu_id_i;
      q_rob_id[wr_ptr]    <= bus.req_rob_id_i;
      q_ld_rd_idx[wr_ptr] <= bus.req_ld_rd_idx_i;
      q_type[wr_ptr]      <= bus.req_type_i;
      q_off[wr_ptr]       <= bus.req_paddr_i[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (dat_hs && empty) proto_err <= 1'b1;
    end
  end

  // p0: head entry lookup and data formatting
  logic [5:0]      type_p0;
  logic [2:0]      off_p0;
  logic            err_p0;
  logic [XLEN-1:0] data_p0;

  assign type_p0 = q_type[rd_ptr];
  assign off_p0  = q_off[rd_ptr];
  assign err_p0  = bus.dat_err_i || misaligned(type_p0, off_p0);
  assign data_p0 = err_p0 ? '0 : fmt_load(type_p0, off_p0, bus.dat_i);

  // p1: response register; fields are zeroed whenever no response is held
  always_ff @(posedge clk) begin
    if (rst || (!pop && bus.resp_rdy_i)) begin
      vld_p1       <= 1'b0;
      lsu_id_p1    <= '0;
      rob_id_p1    <= '0;
      ld_rd_idx_p1 <= '0;
      type_p1      <= '0;
      data_p1      <= '0;
      err_p1       <= 1'b0;
    end else if (pop) begin
      vld_p1       <= 1'b1;
      lsu_id_p1    <= q_lsu_id[rd_ptr];
      rob_id_p1    <= q_rob_id[rd_ptr];
      ld_rd_idx_p1 <= q_ld_rd_idx[rd_ptr];
      type_p1      <= type_p0;
      data_p1      <= data_p0;
      err_p1       <= err_p0;
    end
  end

  assign bus.req_rdy_o        = req_rdy;
  assign bus.dat_rdy_o        = dat_rdy;
  assign bus.resp_vld_o       = vld_p1;
  assign bus.resp_lsu_id_o    = lsu_id_p1;
  assign bus.resp_rob_id_o    = rob_id_p1;
  assign bus.resp_ld_rd_idx_o = ld_rd_idx_p1;
  assign bus.resp_req_type_o  = type_p1;
  assign bus.resp_ld_data_o   = data_p1;
  assign bus.resp_err_o       = err_p1;
  assign bus.count_o          = count;
  assign bus.proto_err_o      = proto_err;
endmodule

// File: tb/tb_ruby_lsu_l1d_resp_fmt.sv
// Bench for ruby_lsu_l1d_resp_fmt: queue-based reference model compared every cycle,
// directed literal cases for formatting, backpressure and protocol errors, then random traffic.
module tb_ruby_lsu_l1d_resp_fmt;
  localparam int LSU_ID_WIDTH   = 4;
  localparam int ROB_TAG_WIDTH  = 6;
  localparam int PREG_TAG_WIDTH = 7;
  localparam int PADDR_WIDTH    = 56;
  localparam int XLEN           = 64;
  localparam int DEPTH          = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ruby_lsu_l1d_resp_fmt_if #(
    .LSU_ID_WIDTH(LSU_ID_WIDTH), .ROB_TAG_WIDTH(ROB_TAG_WIDTH), .PREG_TAG_WIDTH(PREG_TAG_WIDTH),
    .PADDR_WIDTH(PADDR_WIDTH), .XLEN(XLEN), .DEPTH(DEPTH)
  ) bus ();

  ruby_lsu_l1d_resp_fmt #(
    .LSU_ID_WIDTH(LSU_ID_WIDTH), .ROB_TAG_WIDTH(ROB_TAG_WIDTH), .PREG_TAG_WIDTH(PREG_TAG_WIDTH),
    .PADDR_WIDTH(PADDR_WIDTH), .XLEN(XLEN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [LSU_ID_WIDTH-1:0]   lsu;
    logic [ROB_TAG_WIDTH-1:0]  rob;
    logic [PREG_TAG_WIDTH-1:0] rd;
    logic [5:0]                typ;
    logic [2:0]                off;
  } req_t;

  req_t                      mq[$];
  logic                      m_vld, m_err, m_proto, last_stall;
  logic [LSU_ID_WIDTH-1:0]   m_lsu;
  logic [ROB_TAG_WIDTH-1:0]  m_rob;
  logic [PREG_TAG_WIDTH-1:0] m_rd;
  logic [5:0]                m_typ;
  logic [63:0]               m_data;

  int  nchecks = 0;
  int  nfail   = 0;
  bit  chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: pick access bytes one at a time, then extend by the op's kind.
  function automatic void ref_resp(input logic [5:0] typ, input logic [2:0] off,
                                   input logic [63:0] dat, input logic derr,
                                   output logic [63:0] data, output logic err);
    int size, kind;  // kind: 0 zero, 1 sext, 2 zext, 3 raw, 4 nan-box, 5 sc flag
    logic [63:0] v;
    int t;
    t = int'(typ);
    size = 1; kind = 0;
    if (t == 1)                                     begin size = 1; kind = 1; end
    else if (t == 2)                                begin size = 1; kind = 2; end
    else if (t == 3)                                begin size = 2; kind = 1; end
    else if (t == 4)                                begin size = 2; kind = 2; end
    else if (t == 5 || t == 12)                     begin size = 4; kind = 1; end
    else if (t == 6)                                begin size = 4; kind = 2; end
    else if (t == 7 || t == 13 || t == 36)          begin size = 8; kind = 3; end
    else if (t >= 16 && t <= 33 && t % 2 == 0)      begin size = 4; kind = 1; end
    else if (t >= 16 && t <= 33)                    begin size = 8; kind = 3; end
    else if (t == 34)                               begin size = 4; kind = 4; end
    else if (t == 14)                               begin size = 4; kind = 5; end
    else if (t == 15)                               begin size = 8; kind = 5; end
    else if (t == 8)                                begin size = 1; kind = 0; end
    else if (t == 9)                                begin size = 2; kind = 0; end
    else if (t == 10 || t == 35)                    begin size = 4; kind = 0; end
    else if (t == 11 || t == 37)                    begin size = 8; kind = 0; end
    v = '0;
    for (int i = 0; i < size; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = dat[8*(int'(off)+i) +: 8];
    case (kind)
      0: v = '0;
      1: if (size < 8 && v[8*size-1]) for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
      4: v[63:32] = 32'hFFFF_FFFF;
      5: v = {63'd0, dat[0]};
      default: ;
    endcase
    err  = derr || (int'(off) % size != 0);
    data = err ? 64'd0 : v;
  endfunction

  // Model state advances on the same edge the DUT samples.
  int   mn;
  logic m_rdy_d, m_pop, m_e;
  req_t me;
  logic [63:0] md;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_vld = 0; m_lsu = '0; m_rob = '0; m_rd = '0; m_typ = '0; m_data = '0; m_err = 0;
      m_proto = 0; last_stall = 0;
    end else begin
      mn      = mq.size();
      m_rdy_d = !m_vld || bus.resp_rdy_i;
      m_pop   = bus.dat_vld_i && m_rdy_d && mn != 0;
      last_stall = bus.dat_vld_i && !m_rdy_d;
      if (bus.dat_vld_i && m_rdy_d && mn == 0) m_proto = 1;
      if (m_pop) begin
        me = mq.pop_front();
        ref_resp(me.typ, me.off, bus.dat_i, bus.dat_err_i, md, m_e);
        m_vld = 1; m_lsu = me.lsu; m_rob = me.rob; m_rd = me.rd; m_typ = me.typ;
        m_data = md; m_err = m_e;
      end else if (bus.resp_rdy_i) begin
        m_vld = 0; m_lsu = '0; m_rob = '0; m_rd = '0; m_typ = '0; m_data = '0; m_err = 0;
      end
      if (bus.req_vld_i && mn != DEPTH)
        mq.push_back('{bus.req_lsu_id_i, bus.req_rob_id_i, bus.req_ld_rd_idx_i,
                       bus.req_type_i, bus.req_paddr_i[2:0]});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",     64'(bus.count_o),          64'(mq.size()));
      chk("req_rdy",   64'(bus.req_rdy_o),        64'(mq.size() != DEPTH));
      chk("dat_rdy",   64'(bus.dat_rdy_o),        64'(!m_vld || bus.resp_rdy_i));
      chk("resp_vld",  64'(bus.resp_vld_o),       64'(m_vld));
      chk("proto_err", 64'(bus.proto_err_o),      64'(m_proto));
      chk("lsu_id",    64'(bus.resp_lsu_id_o),    64'(m_lsu));
      chk("rob_id",    64'(bus.resp_rob_id_o),    64'(m_rob));
      chk("ld_rd_idx", 64'(bus.resp_ld_rd_idx_o), 64'(m_rd));
      chk("req_type",  64'(bus.resp_req_type_o),  64'(m_typ));
      chk("ld_data",   bus.resp_ld_data_o,        m_data);
      chk("resp_err",  64'(bus.resp_err_o),       64'(m_err));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [5:0] typ, input logic [2:0] off,
                         input logic [ROB_TAG_WIDTH-1:0] rob);
    bus.req_vld_i       = v;
    bus.req_type_i      = typ;
    bus.req_paddr_i     = {53'h1_2345, off};
    bus.req_rob_id_i    = rob;
    bus.req_lsu_id_i    = rob[3:0];
    bus.req_ld_rd_idx_i = {1'b1, rob};
  endtask

  task automatic one_access(input string name, input logic [5:0] typ, input logic [2:0] off,
                            input logic [63:0] dat, input logic [63:0] exp_data,
                            input logic exp_err);
    set_req(1'b1, typ, off, 6'd33);
    cyc();
    bus.req_vld_i = 1'b0;
    bus.dat_vld_i = 1'b1;
    bus.dat_i     = dat;
    bus.dat_err_i = 1'b0;
    cyc();
    bus.dat_vld_i = 1'b0;
    chk({name, "_vld"},  64'(bus.resp_vld_o), 64'd1);
    chk({name, "_data"}, bus.resp_ld_data_o,  exp_data);
    chk({name, "_err"},  64'(bus.resp_err_o), 64'(exp_err));
    chk({name, "_rob"},  64'(bus.resp_rob_id_o), 64'd33);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [2:0]  msk;
    set_req(1'b0, 6'd0, 3'd0, 6'd0);
    bus.dat_vld_i  = 1'b0;
    bus.dat_i      = '0;
    bus.dat_err_i  = 1'b0;
    bus.resp_rdy_i = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    cyc();
    chk("rst_resp_vld", 64'(bus.resp_vld_o),  64'd0);
    chk("rst_count",    64'(bus.count_o),     64'd0);
    chk("rst_req_rdy",  64'(bus.req_rdy_o),   64'd1);
    chk("rst_dat_rdy",  64'(bus.dat_rdy_o),   64'd1);
    chk("rst_proto",    64'(bus.proto_err_o), 64'd0);
    chk("rst_data",     bus.resp_ld_data_o,   64'd0);
    rst = 1'b0;
    cyc();

    one_access("lb",  6'd1,  3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    one_access("flw", 6'd34, 3'd4, 64'h3F80_0000_1234_5678, 64'hFFFF_FFFF_3F80_0000, 1'b0);
    one_access("lwu", 6'd6,  3'd4, 64'h3F80_0000_1234_5678, 64'h0000_0000_3F80_0000, 1'b0);
    one_access("lh_mis", 6'd3, 3'd1, 64'h1122_3344_5566_7788, 64'd0, 1'b1);
    one_access("scd", 6'd15, 3'd0, 64'hDEAD_BEEF_0000_0001, 64'd1, 1'b0);
    one_access("lhu", 6'd4,  3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 1'b0);

    // Fill the queue with the response path blocked.
    bus.resp_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 6'd7, 3'd0, 6'(10 + i));
      cyc();
    end
    chk("full_req_rdy", 64'(bus.req_rdy_o), 64'd0);
    chk("full_count",   64'(bus.count_o),   64'd4);
    set_req(1'b1, 6'd7, 3'd0, 6'd30);
    bus.dat_vld_i = 1'b1;
    bus.dat_i     = 64'hA000_0000_0000_0000;
    cyc();
    bus.req_vld_i = 1'b0;
    chk("full_nopush_count", 64'(bus.count_o), 64'd3);
    bus.dat_i = 64'hA000_0000_0000_0001;
    for (int i = 0; i < 3; i++) begin
      chk("stall_dat_rdy", 64'(bus.dat_rdy_o),     64'd0);
      chk("stall_rob",     64'(bus.resp_rob_id_o), 64'd10);
      chk("stall_data",    bus.resp_ld_data_o,     64'hA000_0000_0000_0000);
      cyc();
    end
    bus.resp_rdy_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.dat_i = 64'hA000_0000_0000_0000 + 64'(i);
      cyc();
      chk("drain_rob",  64'(bus.resp_rob_id_o), 64'(10 + i));
      chk("drain_data", bus.resp_ld_data_o,     64'hA000_0000_0000_0000 + 64'(i));
    end
    bus.dat_vld_i = 1'b0;
    cyc();
    chk("drain_empty", 64'(bus.count_o), 64'd0);

    // Data with nothing queued.
    bus.dat_vld_i = 1'b1;
    cyc();
    bus.dat_vld_i = 1'b0;
    chk("spur_proto", 64'(bus.proto_err_o), 64'd1);
    chk("spur_vld",   64'(bus.resp_vld_o),  64'd0);
    cyc();
    chk("spur_sticky", 64'(bus.proto_err_o), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("spur_rst_proto", 64'(bus.proto_err_o), 64'd0);
    chk("spur_rst_count", 64'(bus.count_o),     64'd0);

    // Push and pop together at count 2.
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 6'd7, 3'd0, 6'(20 + i));
      cyc();
    end
    set_req(1'b1, 6'd7, 3'd0, 6'd22);
    bus.dat_vld_i = 1'b1;
    bus.dat_i     = 64'h55;
    cyc();
    bus.req_vld_i = 1'b0;
    chk("pp_count", 64'(bus.count_o),       64'd2);
    chk("pp_rob",   64'(bus.resp_rob_id_o), 64'd20);
    cyc();
    cyc();
    bus.dat_vld_i = 1'b0;
    cyc();
    chk("pp_drained", 64'(bus.count_o), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      msk = 3'($urandom_range(0, 3) == 0 ? 7 : ($urandom_range(0, 1) ? 4 : 0));
      set_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 40)),
              3'($urandom_range(0, 7)) & msk, 6'($urandom));
      bus.req_lsu_id_i    = 4'($urandom);
      bus.req_ld_rd_idx_i = 7'($urandom);
      if (!last_stall) begin
        r64 = {$urandom, $urandom};
        bus.dat_vld_i = ($urandom_range(0, 3) != 0);
        bus.dat_i     = r64;
        bus.dat_err_i = ($urandom_range(0, 7) == 0);
      end
      bus.resp_rdy_i = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0;
    set_req(1'b0, 6'd0, 3'd0, 6'd0);
    bus.dat_vld_i  = 1'b0;
    bus.resp_rdy_i = 1'b1;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
